// File: rtl/text_writer_if.sv
// Byte-stream input and character-RAM write port of the text writer,
// with the cursor and busy status that travel alongside them.
interface text_writer_if #(
   parameter int COLS       = 16,
   parameter int ROWS       = 8,
   parameter int addr_width = 7,
   parameter int data_width = 8
);
   logic [7:0]              in_data;
   logic                    in_valid;
   logic                    in_ready;
   logic [addr_width-1:0]   waddr;
   logic [data_width-1:0]   din;
   logic                    write_en;
   logic [$clog2(ROWS)-1:0] cur_row;
   logic [$clog2(COLS)-1:0] cur_col;
   logic                    busy;

   modport master (
      output in_data, in_valid,
      input  in_ready, waddr, din, write_en, cur_row, cur_col, busy
   );

   modport slave (
      input  in_data, in_valid,
      output in_ready, waddr, din, write_en, cur_row, cur_col, busy
   );
endinterface

// File: rtl/text_writer.sv
// Character-RAM write sequencer: turns a byte stream into cursor-tracked cell
// writes and performs BLANK clear sweeps (whole screen or one row).
module text_writer #(
   parameter int COLS       = 16,
   parameter int ROWS       = 8,
   parameter int addr_width = 7,
   parameter int data_width = 8,
   parameter logic [data_width-1:0] BLANK = data_width'(8'h20)
) (
   input logic          clk,
   input logic          rstn,
   text_writer_if.slave bus
);
   localparam int RW = $clog2(ROWS);
   localparam int CW = $clog2(COLS);

   localparam logic [addr_width-1:0] COLS_A       = addr_width'(COLS);
   localparam logic [addr_width-1:0] LAST_ROW_OFS = addr_width'(COLS - 1);
   localparam logic [addr_width-1:0] LAST_CELL    = addr_width'(ROWS * COLS - 1);
   localparam logic [RW-1:0]         ROW_MAX      = RW'(ROWS - 1);
   localparam logic [CW-1:0]         COL_MAX      = CW'(COLS - 1);

   localparam logic [7:0] C_BS    = 8'h08;
   localparam logic [7:0] C_LF    = 8'h0A;
   localparam logic [7:0] C_FF    = 8'h0C;
   localparam logic [7:0] C_CR    = 8'h0D;
   localparam logic [7:0] C_FIRST = 8'h20;
   localparam logic [7:0] C_LAST  = 8'h7E;

   typedef enum logic [1:0] {
      IDLE,
      CLR_ALL,
      CLR_ROW
   } state_e;

   state_e                  state_q, state_d;
   logic [addr_width-1:0]   sweep_addr_q, sweep_addr_d;
   logic [addr_width-1:0]   sweep_last_q, sweep_last_d;
   logic [RW-1:0]           row_q, row_d;
   logic [CW-1:0]           col_q, col_d;
   logic                    write_en_q, write_en_d;
   logic [addr_width-1:0]   waddr_q, waddr_d;
   logic [data_width-1:0]   din_q, din_d;

   logic [addr_width-1:0]   cell_addr;
   logic [RW-1:0]           next_row;
   logic                    line_feed;

   always_comb begin
      state_d      = state_q;
      sweep_addr_d = sweep_addr_q;
      sweep_last_d = sweep_last_q;
      row_d        = row_q;
      col_d        = col_q;
      write_en_d   = 1'b0;
      waddr_d      = waddr_q;
      din_d        = din_q;
      line_feed    = 1'b0;

      cell_addr = addr_width'(row_q) * COLS_A + addr_width'(col_q);
      next_row  = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;

      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               if (bus.in_data >= C_FIRST && bus.in_data <= C_LAST) begin
                  write_en_d = 1'b1;
                  waddr_d    = cell_addr;
                  din_d      = data_width'(bus.in_data);
                  if (col_q != COL_MAX) begin
                     col_d = col_q + 1'b1;
                  end else begin
                     line_feed = 1'b1;
                  end
               end else begin
                  case (bus.in_data)
                     C_LF: line_feed = 1'b1;
                     C_CR: col_d = '0;
                     C_BS: begin
                        // Backspace stops at column 0; it never climbs to the previous row.
                        if (col_q != '0) begin
                           col_d      = col_q - 1'b1;
                           write_en_d = 1'b1;
                           waddr_d    = cell_addr - 1'b1;
                           din_d      = BLANK;
                        end
                     end
                     C_FF: begin
                        row_d        = '0;
                        col_d        = '0;
                        sweep_addr_d = '0;
                        sweep_last_d = LAST_CELL;
                        state_d      = CLR_ALL;
                     end
                     default: ;
                  endcase
               end

               // Wrap (auto or LF) moves to the next row and blanks it; no scrolling.
               if (line_feed) begin
                  col_d        = '0;
                  row_d        = next_row;
                  sweep_addr_d = addr_width'(next_row) * COLS_A;
                  sweep_last_d = sweep_addr_d + LAST_ROW_OFS;
                  state_d      = CLR_ROW;
               end
            end
         end

         CLR_ROW, CLR_ALL: begin
            write_en_d   = 1'b1;
            waddr_d      = sweep_addr_q;
            din_d        = BLANK;
            sweep_addr_d = sweep_addr_q + 1'b1;
            if (sweep_addr_q == sweep_last_q) begin
               state_d = IDLE;
            end
         end

         default: state_d = CLR_ALL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q      <= CLR_ALL;
         sweep_addr_q <= '0;
         sweep_last_q <= LAST_CELL;
         row_q        <= '0;
         col_q        <= '0;
         write_en_q   <= 1'b0;
         waddr_q      <= '0;
         din_q        <= '0;
      end else begin
         state_q      <= state_d;
         sweep_addr_q <= sweep_addr_d;
         sweep_last_q <= sweep_last_d;
         row_q        <= row_d;
         col_q        <= col_d;
         write_en_q   <= write_en_d;
         waddr_q      <= waddr_d;
         din_q        <= din_d;
      end
   end

   assign bus.in_ready = (state_q == IDLE);
   assign bus.busy     = (state_q != IDLE);
   assign bus.write_en = write_en_q;
   assign bus.waddr    = waddr_q;
   assign bus.din      = din_q;
   assign bus.cur_row  = row_q;
   assign bus.cur_col  = col_q;
endmodule
